// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch requester.
// Owns the architectural PC and issues one word request at a time on the
// instruction bus. It presents each fetched word with its PC until the decode
// stage consumes it, and it absorbs redirects at any point of a transaction.
// Optional build macro IFETCH_PERF_EN enables the stall and discard
// performance counters. When it is undefined, both counter outputs are tied to 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_REQ   | request for pc driven on the bus (suppressed if misaligned)
// ST_WAIT  | address accepted, waiting for data_ok
// ST_HOLD  | fetched word (or misaligned-PC slot) presented downstream
// discard  | the in-flight response belongs to a redirected-away PC

module ifetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        instr_valid,
    output logic [31:0] raw_instr,
    output logic [63:0] pc_out,
    output logic        stall,
    output logic        pc_misaligned,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] perf_stall_cnt,
    output logic [63:0] perf_discard_cnt
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [63:0] target, target_n;
    logic        discard, discard_n;
    logic [31:0] instr_q, instr_n;
    logic [63:0] pc_out_q, pc_out_n;
    logic        mis_q, mis_n;
    logic        pc_aligned;
    logic        data_arrive;

    assign pc_aligned  = (pc[1:0] == 2'b00);

    // The response closes the outstanding transaction. This happens in
    // ST_REQ only when the address is accepted in the same cycle.
    assign data_arrive = ((state == ST_REQ) && pc_aligned && iresp_addr_ok && iresp_data_ok)
                       || ((state == ST_WAIT) && iresp_data_ok);

    assign ireq_valid    = (state == ST_REQ) && pc_aligned && !reset;
    assign ireq_addr     = pc;
    assign instr_valid   = (state == ST_HOLD);
    assign stall         = ~instr_valid;
    assign raw_instr     = instr_valid ? instr_q : 32'h0;
    assign pc_misaligned = instr_valid & mis_q;
    assign pc_out        = pc_out_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_REQ;
            pc       <= RESET_PC;
            target   <= RESET_PC;
            discard  <= 1'b0;
            instr_q  <= 32'h0;
            pc_out_q <= RESET_PC;
            mis_q    <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            target   <= target_n;
            discard  <= discard_n;
            instr_q  <= instr_n;
            pc_out_q <= pc_out_n;
            mis_q    <= mis_n;
        end
    end

    // Next-state logic. A redirect wins over every other event. While a
    // request is in flight, the issued pc is kept on the bus, and the
    // redirect target waits in `target` until the response is dropped.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        target_n  = target;
        discard_n = discard;
        instr_n   = instr_q;
        pc_out_n  = pc_out_q;
        mis_n     = mis_q;

        if (data_arrive) begin
            if (redirect_valid) begin
                state_n   = ST_REQ;
                pc_n      = redirect_pc;
                discard_n = 1'b0;
            end else if (discard) begin
                state_n   = ST_REQ;
                pc_n      = target;
                discard_n = 1'b0;
            end else begin
                state_n   = ST_HOLD;
                instr_n   = iresp_data;
                pc_out_n  = pc;
                mis_n     = 1'b0;
            end
        end else begin
            case (state)
                ST_REQ: begin
                    if (!pc_aligned) begin
                        if (redirect_valid) begin
                            pc_n = redirect_pc;
                        end else begin
                            state_n  = ST_HOLD;
                            instr_n  = 32'h0;
                            pc_out_n = pc;
                            mis_n    = 1'b1;
                        end
                    end else begin
                        if (iresp_addr_ok) begin
                            state_n = ST_WAIT;
                        end
                        if (redirect_valid) begin
                            discard_n = 1'b1;
                            target_n  = redirect_pc;
                        end
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        discard_n = 1'b1;
                        target_n  = redirect_pc;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        state_n = ST_REQ;
                        pc_n    = redirect_pc;
                    end else if (instr_ready) begin
                        state_n = ST_REQ;
                        pc_n    = pc + 64'd4;
                    end
                end
                default: begin
                    state_n = ST_REQ;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic [63:0] stall_cnt_q;
    logic [63:0] discard_cnt_q;
    logic        drop;

    assign drop = data_arrive && (redirect_valid || discard);

    // Count stalled cycles and dropped responses; both wrap at 2^64.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q   <= 64'h0;
            discard_cnt_q <= 64'h0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 64'd1;
            end
            if (drop) begin
                discard_cnt_q <= discard_cnt_q + 64'd1;
            end
        end
    end

    assign perf_stall_cnt   = stall_cnt_q;
    assign perf_discard_cnt = discard_cnt_q;
`else
    assign perf_stall_cnt   = 64'h0;
    assign perf_discard_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit. A table of per-cycle vectors is used:
// inputs are driven just after the falling edge, and outputs are compared 1
// time unit later, before the next rising edge.
module tb_ifetch_unit;

    localparam logic [63:0] B = 64'h8000_0000;
    localparam logic [63:0] TOPW = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        instr_valid;
    logic [31:0] raw_instr;
    logic [63:0] pc_out;
    logic        stall;
    logic        pc_misaligned;
    logic        instr_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] perf_stall_cnt;
    logic [63:0] perf_discard_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(B)) dut (
        .clk              (clk),
        .reset            (reset),
        .ireq_valid       (ireq_valid),
        .ireq_addr        (ireq_addr),
        .iresp_addr_ok    (iresp_addr_ok),
        .iresp_data_ok    (iresp_data_ok),
        .iresp_data       (iresp_data),
        .instr_valid      (instr_valid),
        .raw_instr        (raw_instr),
        .pc_out           (pc_out),
        .stall            (stall),
        .pc_misaligned    (pc_misaligned),
        .instr_ready      (instr_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_discard_cnt (perf_discard_cnt)
    );

    typedef struct {
        logic        rst;
        logic        aok;
        logic        dok;
        logic [31:0] data;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_raw;
        logic [63:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic aok, logic dok, logic [31:0] data,
                                logic rdy, logic rv, logic [63:0] rpc,
                                logic e_rv, logic [63:0] e_addr, logic e_iv,
                                logic [31:0] e_raw, logic [63:0] e_pc, logic e_mis);
        vec_t v;
        v.rst = rst; v.aok = aok; v.dok = dok; v.data = data; v.rdy = rdy;
        v.rv = rv; v.rpc = rpc; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_raw = e_raw; v.e_pc = e_pc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic aok, input logic dok, input logic [31:0] data,
                         input logic rdy, input logic rv, input logic [63:0] rpc);
        @(negedge clk);
        reset = rst; iresp_addr_ok = aok; iresp_data_ok = dok; iresp_data = data;
        instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
    endtask

    initial begin
        reset = 1'b1; iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state, sampled while reset is still asserted
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rst ireq_valid", 64'(ireq_valid), 0);
        check("rst instr_valid", 64'(instr_valid), 0);
        check("rst raw_instr", 64'(raw_instr), 0);
        check("rst pc_out", pc_out, B);
        check("rst pc_misaligned", 64'(pc_misaligned), 0);
        check("rst stall", 64'(stall), 1);
        check("rst perf_stall", perf_stall_cnt, 0);
        check("rst perf_discard", perf_discard_cnt, 0);

        //              rst aok dok data          rdy rv rpc       | e_rv e_addr    e_iv e_raw          e_pc       e_mis
        vecs.push_back(mk(0, 1, 1, 32'h0000_0013, 1, 0, 0,           1, B,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             1, 0, 0,           0, 0,          1, 32'h13,        B,         0));
        vecs.push_back(mk(0, 1, 0, 0,             0, 0, 0,           1, B+4,        0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,           0, 0,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,           0, 0,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 1, 32'h0010_0093, 0, 0, 0,           0, 0,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,           0, 0,          1, 32'h0010_0093, B+4,       0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,           0, 0,          1, 32'h0010_0093, B+4,       0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,           0, 0,          1, 32'h0010_0093, B+4,       0));
        vecs.push_back(mk(0, 0, 0, 0,             1, 0, 0,           0, 0,          1, 32'h0010_0093, B+4,       0));
        vecs.push_back(mk(0, 1, 0, 0,             0, 0, 0,           1, B+8,        0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 1, B+'h100,     0, 0,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0,           0, 0,          0, 0,             0,         0));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0093, 0, 0, 0,           1, B+'h100,    0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             1, 1, B+'h102,     0, 0,          1, 32'h93,        B+'h100,   0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,           0, 0,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,           0, 0,          1, 0,             B+'h102,   1));
        vecs.push_back(mk(0, 0, 0, 0,             0, 1, B+'h200,     0, 0,          1, 0,             B+'h102,   1));
        vecs.push_back(mk(0, 0, 0, 0,             0, 1, B+'h300,     1, B+'h200,    0, 0,             0,         0));
        vecs.push_back(mk(0, 1, 0, 0,             0, 0, 0,           1, B+'h200,    0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 1, B+'h400,     0, 0,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 1, 32'hBAD0_BAD0, 0, 0, 0,           0, 0,          0, 0,             0,         0));
        vecs.push_back(mk(0, 1, 0, 0,             0, 0, 0,           1, B+'h400,    0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 1, 32'h1111_1111, 0, 1, B+'h500,     0, 0,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,           1, B+'h500,    0, 0,             0,         0));
        vecs.push_back(mk(0, 1, 0, 0,             0, 0, 0,           1, B+'h500,    0, 0,             0,         0));
        vecs.push_back(mk(1, 0, 0, 0,             0, 0, 0,           0, 0,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 1, 32'hDEAD_DEAD, 0, 0, 0,           1, B,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,           1, B,          0, 0,             0,         0));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0073, 0, 0, 0,           1, B,          0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             1, 1, TOPW,        0, 0,          1, 32'h73,        B,         0));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0013, 0, 0, 0,           1, TOPW,       0, 0,             0,         0));
        vecs.push_back(mk(0, 0, 0, 0,             1, 0, 0,           0, 0,          1, 32'h13,        TOPW,      0));
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,           1, 64'h0,      0, 0,             0,         0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].aok, vecs[i].dok, vecs[i].data,
                  vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            check($sformatf("v%0d ireq_valid", i), 64'(ireq_valid), 64'(vecs[i].e_rv));
            if (vecs[i].e_rv)
                check($sformatf("v%0d ireq_addr", i), ireq_addr, vecs[i].e_addr);
            check($sformatf("v%0d instr_valid", i), 64'(instr_valid), 64'(vecs[i].e_iv));
            check($sformatf("v%0d stall", i), 64'(stall), 64'(!vecs[i].e_iv));
            check($sformatf("v%0d raw_instr", i), 64'(raw_instr), 64'(vecs[i].e_raw));
            check($sformatf("v%0d pc_misaligned", i), 64'(pc_misaligned), 64'(vecs[i].e_mis));
            if (vecs[i].e_iv)
                check($sformatf("v%0d pc_out", i), pc_out, vecs[i].e_pc);
        end

        // Hand sequence: redirect in WAIT, then the dropped response; the
        // counters restart from this reset.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, B+'h40);
        drive(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        drive(0, 1, 1, 32'h0000_0013, 0, 0, 0);
        check("seq ireq_valid", 64'(ireq_valid), 1);
        check("seq ireq_addr", ireq_addr, B+'h40);
        check("seq instr_valid", 64'(instr_valid), 0);
`ifdef IFETCH_PERF_EN
        check("seq perf_discard", perf_discard_cnt, 1);
        check("seq perf_stall", perf_stall_cnt, 3);
`else
        check("seq perf_discard", perf_discard_cnt, 0);
        check("seq perf_stall", perf_stall_cnt, 0);
`endif
        drive(0, 0, 0, 0, 0, 0, 0);
        check("seq hold instr_valid", 64'(instr_valid), 1);
        check("seq hold raw_instr", 64'(raw_instr), 32'h13);
        check("seq hold pc_out", pc_out, B+'h40);
        drive(0, 0, 0, 0, 0, 0, 0);
`ifdef IFETCH_PERF_EN
        check("seq perf_stall hold", perf_stall_cnt, 4);
`else
        check("seq perf_stall hold", perf_stall_cnt, 0);
`endif
        check("seq perf_discard hold", perf_discard_cnt,
`ifdef IFETCH_PERF_EN
              1
`else
              0
`endif
        );

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
